// File: rtl/error_report_arbiter_pkg.sv
// error_report_arbiter_pkg: shared FSM states and error vector types for the error-report arbiter.
package error_report_arbiter_pkg;
  localparam int ERROR_VECTOR_WIDTH = 64;
  typedef logic [0:ERROR_VECTOR_WIDTH-1] error_vector_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_REPORT, ARB_CLEAR} error_arb_state;
endpackage

// File: rtl/error_report_arbiter_if.sv
// error_report_arbiter_if: engine/host-facing signals of the error-report arbiter.
interface error_report_arbiter_if #(parameter int NUM_SOURCES = 4);
  import error_report_arbiter_pkg::*;
  localparam int SW = $clog2(NUM_SOURCES);
  logic enabled;
  error_vector_t [NUM_SOURCES-1:0] source_errors;
  logic report_errors_ack;
  logic report_valid;
  error_vector_t report_errors;
  logic [SW-1:0] report_source;
  logic [NUM_SOURCES-1:0] source_clear_n;
  logic errors_pending;
  logic report_timeout;
  modport master (
    output enabled, source_errors, report_errors_ack,
    input report_valid, report_errors, report_source, source_clear_n, errors_pending, report_timeout
  );
  modport slave (
    input enabled, source_errors, report_errors_ack,
    output report_valid, report_errors, report_source, source_clear_n, errors_pending, report_timeout
  );
endinterface

// File: rtl/error_report_arbiter_rr_priority_select.sv
// rr_priority_select: picks the first set request at or after ptr_i, wrapping around.
module rr_priority_select #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);
  logic [W-1:0] cand;
  always_comb begin
    idx_o = '0;
    found_o = 1'b0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = W'((int'(ptr_i) + k) % N);
      if (req_i[cand]) begin
        idx_o = cand;
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/error_report_arbiter.sv
// error_report_arbiter: sticky per-source error latches shared round-robin onto one MMIO report path.
// Optional ack-wait timeout enabled by defining ERROR_ARB_TIMEOUT_EN.
module error_report_arbiter
  import error_report_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clock,
  input logic rstn,
  error_report_arbiter_if.slave bus
);
  localparam int SW = $clog2(NUM_SOURCES);
  error_arb_state state_q, state_d;
  error_vector_t [NUM_SOURCES-1:0] latch_q, latch_d;
  error_vector_t snap_q, snap_d;
  logic [SW-1:0] src_q, src_d, rr_q, rr_d, sel_idx;
  logic [NUM_SOURCES-1:0] clear_n_q, clear_n_d, req;
  logic valid_q, valid_d, pending_q, pending_d, timeout_q, timeout_d;
  logic sel_found, any_next, done, hit;

  rr_priority_select #(.N(NUM_SOURCES)) u_sel (
    .req_i  (req),
    .ptr_i  (rr_q),
    .idx_o  (sel_idx),
    .found_o(sel_found)
  );

`ifdef ERROR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = state_q == ARB_REPORT ? cnt_q + CW'(1) : '0;
  assign hit = state_q == ARB_REPORT && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign hit = 1'b0;
`endif

  // Idle looks at next-cycle latch contents so a fresh error reaches GRANT one cycle later.
  assign any_next = |(latch_q | bus.source_errors);
  assign done = bus.report_errors_ack | hit;

  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      req[i] = |latch_q[i];
      latch_d[i] = latch_q[i] | bus.source_errors[i];
    end
    src_d = src_q;
    snap_d = snap_q;
    valid_d = valid_q;
    clear_n_d = '1;
    rr_d = rr_q;
    pending_d = |latch_q;
    timeout_d = timeout_q | hit;
    if (state_q == ARB_GRANT) begin
      src_d = sel_idx;
      snap_d = latch_q[sel_idx];
      valid_d = sel_found;
    end
    if (state_q == ARB_REPORT && done) begin
      valid_d = 1'b0;
      clear_n_d[src_q] = 1'b0;
    end
    // Bits that arrived after the snapshot stay latched for a later report.
    if (state_q == ARB_CLEAR) begin
      latch_d[src_q] = (latch_q[src_q] & ~snap_q) | bus.source_errors[src_q];
      rr_d = src_q == SW'(NUM_SOURCES - 1) ? '0 : src_q + SW'(1);
    end
    state_d = state_q == ARB_IDLE   ? (bus.enabled && any_next ? ARB_GRANT : ARB_IDLE) :
              state_q == ARB_GRANT  ? ARB_REPORT :
              state_q == ARB_REPORT ? (done ? ARB_CLEAR : ARB_REPORT) : ARB_IDLE;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
      latch_q <= '0;
      snap_q <= '0;
      src_q <= '0;
      rr_q <= '0;
      valid_q <= 1'b0;
      clear_n_q <= '1;
      pending_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      snap_q <= snap_d;
      src_q <= src_d;
      rr_q <= rr_d;
      valid_q <= valid_d;
      clear_n_q <= clear_n_d;
      pending_q <= pending_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.report_valid = valid_q;
  assign bus.report_errors = snap_q;
  assign bus.report_source = src_q;
  assign bus.source_clear_n = clear_n_q;
  assign bus.errors_pending = pending_q;
  assign bus.report_timeout = timeout_q;
endmodule

// File: tb/tb_error_report_arbiter.sv
// tb_error_report_arbiter: directed scenarios for error_report_arbiter with hand-computed expectations.
module tb_error_report_arbiter;
  import error_report_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  error_report_arbiter_if #(.NUM_SOURCES(4)) bus ();
  error_report_arbiter #(.NUM_SOURCES(4), .TIMEOUT_CYCLES(8)) dut (
    .clock(clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.source_errors = '0;
    bus.report_errors_ack = 1'b0;
    bus.enabled = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    step();
  endtask

  task automatic wait_report(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < n && !ok; i++) begin
      step();
      ok = bus.report_valid;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if ({bus.report_valid, bus.report_source, bus.source_clear_n, bus.errors_pending, bus.report_timeout} !== 9'b0_00_1111_0_0) begin
      errs++;
      $display("FAIL reset_outputs: got valid=%b src=%0d clr=%b pend=%b to=%b want 0 0 1111 0 0",
               bus.report_valid, bus.report_source, bus.source_clear_n, bus.errors_pending, bus.report_timeout);
    end
    vecs++;
    if (bus.report_errors !== 64'h0) begin errs++; $display("FAIL reset_errors: got %h want 0", bus.report_errors); end
  endtask

  task automatic test_single();
    do_reset();
    bus.source_errors[2] = 64'h1;
    step();
    bus.source_errors = '0;
    vecs++;
    if (bus.report_valid !== 1'b0) begin errs++; $display("FAIL single_valid_c1: got %b want 0", bus.report_valid); end
    step();
    vecs++;
    if (bus.report_valid !== 1'b1) begin errs++; $display("FAIL single_valid_c2: got %b want 1", bus.report_valid); end
    vecs++;
    if (bus.report_source !== 2'd2) begin errs++; $display("FAIL single_source: got %0d want 2", bus.report_source); end
    vecs++;
    if (bus.report_errors !== 64'h1) begin errs++; $display("FAIL single_errors: got %h want 1", bus.report_errors); end
    vecs++;
    if (bus.errors_pending !== 1'b1) begin errs++; $display("FAIL single_pending_set: got %b want 1", bus.errors_pending); end
    bus.report_errors_ack = 1'b1;
    step();
    bus.report_errors_ack = 1'b0;
    vecs++;
    if (bus.source_clear_n !== 4'b1011) begin errs++; $display("FAIL single_clear_pulse: got %b want 1011", bus.source_clear_n); end
    vecs++;
    if (bus.report_valid !== 1'b0) begin errs++; $display("FAIL single_valid_drop: got %b want 0", bus.report_valid); end
    step();
    vecs++;
    if (bus.source_clear_n !== 4'b1111) begin errs++; $display("FAIL single_clear_end: got %b want 1111", bus.source_clear_n); end
    step();
    vecs++;
    if (bus.errors_pending !== 1'b0) begin errs++; $display("FAIL single_pending_clr: got %b want 0", bus.errors_pending); end
    repeat (3) step();
    vecs++;
    if (bus.report_valid !== 1'b0) begin errs++; $display("FAIL single_no_rereport: got %b want 0", bus.report_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_src [7] = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd0};
    logic [63:0] exp_val [7] = '{64'h1, 64'h2, 64'h4, 64'h8, 64'h20, 64'h10, 64'h0};
    bit ok;
    do_reset();
    bus.report_errors_ack = 1'b1;
    bus.source_errors[0] = 64'h1;
    bus.source_errors[1] = 64'h2;
    bus.source_errors[3] = 64'h4;
    step();
    bus.source_errors = '0;
    for (int r = 0; r < 6; r++) begin
      // Lone source-1 report moves rr_ptr to 2, so the 0/3 burst comes out as 3 then 0.
      if (r == 3) bus.source_errors[1] = 64'h8;
      if (r == 4) begin bus.source_errors[0] = 64'h10; bus.source_errors[3] = 64'h20; end
      if (r >= 3) begin step(); bus.source_errors = '0; end
      wait_report(8, ok);
      vecs++;
      if (!ok) begin errs++; $display("FAIL rr_timeout_%0d: got no report_valid want report", r); end
      vecs++;
      if (bus.report_source !== exp_src[r] || bus.report_errors !== exp_val[r]) begin
        errs++;
        $display("FAIL rr_order_%0d: got src=%0d err=%h want src=%0d err=%h", r,
                 bus.report_source, bus.report_errors, exp_src[r], exp_val[r]);
      end
      step();
      vecs++;
      if (bus.report_valid !== 1'b0) begin errs++; $display("FAIL rr_one_cycle_%0d: got %b want 0", r, bus.report_valid); end
    end
    bus.report_errors_ack = 1'b0;
    repeat (3) step();
    vecs++;
    if (bus.errors_pending !== 1'b0) begin errs++; $display("FAIL rr_drained: got %b want 0", bus.errors_pending); end
  endtask

  task automatic test_mid_report();
    bit ok;
    do_reset();
    bus.source_errors[1] = 64'h0F;
    step();
    bus.source_errors = '0;
    wait_report(4, ok);
    vecs++;
    if (!ok || bus.report_source !== 2'd1 || bus.report_errors !== 64'h0F) begin
      errs++;
      $display("FAIL mid_first: got ok=%b src=%0d err=%h want 1 1 0f", ok, bus.report_source, bus.report_errors);
    end
    bus.source_errors[1] = 64'hF0;
    step();
    bus.source_errors = '0;
    vecs++;
    if (bus.report_valid !== 1'b1 || bus.report_errors !== 64'h0F) begin
      errs++;
      $display("FAIL mid_stable: got valid=%b err=%h want 1 0f", bus.report_valid, bus.report_errors);
    end
    bus.report_errors_ack = 1'b1;
    step();
    bus.report_errors_ack = 1'b0;
    vecs++;
    if (bus.source_clear_n !== 4'b1101) begin errs++; $display("FAIL mid_clear: got %b want 1101", bus.source_clear_n); end
    wait_report(6, ok);
    vecs++;
    if (!ok || bus.report_source !== 2'd1 || bus.report_errors !== 64'hF0) begin
      errs++;
      $display("FAIL mid_second: got ok=%b src=%0d err=%h want 1 1 f0", ok, bus.report_source, bus.report_errors);
    end
    bus.report_errors_ack = 1'b1;
    step();
    bus.report_errors_ack = 1'b0;
    step();
  endtask

  task automatic test_enable();
    bit ok;
    bit seen = 1'b0;
    do_reset();
    bus.enabled = 1'b0;
    bus.source_errors[0] = 64'hAA;
    step();
    bus.source_errors = '0;
    repeat (6) begin step(); seen |= bus.report_valid; end
    vecs++;
    if (seen !== 1'b0) begin errs++; $display("FAIL en_blocked: got valid seen=%b want 0", seen); end
    vecs++;
    if (bus.errors_pending !== 1'b1) begin errs++; $display("FAIL en_pending: got %b want 1", bus.errors_pending); end
    bus.enabled = 1'b1;
    wait_report(2, ok);
    vecs++;
    if (!ok || bus.report_source !== 2'd0 || bus.report_errors !== 64'hAA) begin
      errs++;
      $display("FAIL en_report: got ok=%b src=%0d err=%h want 1 0 aa", ok, bus.report_source, bus.report_errors);
    end
    bus.report_errors_ack = 1'b1;
    step();
    bus.report_errors_ack = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit pulse = 1'b0;
    bit seen = 1'b0;
    do_reset();
    bus.source_errors[3] = 64'h5;
    bus.source_errors[2] = 64'h7;
    step();
    bus.source_errors = '0;
    wait_report(4, ok);
    vecs++;
    if (!ok || bus.report_source !== 2'd2) begin errs++; $display("FAIL rstmid_enter: got ok=%b src=%0d want 1 2", ok, bus.report_source); end
    #2 rstn = 1'b0;
    #1;
    vecs++;
    if ({bus.report_valid, bus.report_source, bus.source_clear_n, bus.errors_pending, bus.report_timeout} !== 9'b0_00_1111_0_0
        || bus.report_errors !== 64'h0) begin
      errs++;
      $display("FAIL rstmid_async: got valid=%b src=%0d clr=%b pend=%b to=%b err=%h want 0 0 1111 0 0 0",
               bus.report_valid, bus.report_source, bus.source_clear_n, bus.errors_pending, bus.report_timeout, bus.report_errors);
    end
    step();
    rstn = 1'b1;
    repeat (6) begin step(); pulse |= (bus.source_clear_n !== 4'b1111); seen |= bus.report_valid | bus.errors_pending; end
    vecs++;
    if (pulse !== 1'b0 || seen !== 1'b0) begin errs++; $display("FAIL rstmid_dropped: got pulse=%b activity=%b want 0 0", pulse, seen); end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    bus.source_errors[2] = 64'h3;
    step();
    bus.source_errors = '0;
    wait_report(4, ok);
    vecs++;
    if (!ok) begin errs++; $display("FAIL to_enter: got no report_valid want report"); end
`ifdef ERROR_ARB_TIMEOUT_EN
    repeat (7) step();
    vecs++;
    if (bus.report_timeout !== 1'b0 || bus.report_valid !== 1'b1) begin
      errs++;
      $display("FAIL to_early: got to=%b valid=%b want 0 1", bus.report_timeout, bus.report_valid);
    end
    step();
    vecs++;
    if (bus.report_timeout !== 1'b1 || bus.source_clear_n !== 4'b1011 || bus.report_valid !== 1'b0) begin
      errs++;
      $display("FAIL to_fire: got to=%b clr=%b valid=%b want 1 1011 0", bus.report_timeout, bus.source_clear_n, bus.report_valid);
    end
    repeat (4) step();
    vecs++;
    if (bus.report_timeout !== 1'b1 || bus.report_valid !== 1'b0 || bus.errors_pending !== 1'b0) begin
      errs++;
      $display("FAIL to_sticky: got to=%b valid=%b pend=%b want 1 0 0", bus.report_timeout, bus.report_valid, bus.errors_pending);
    end
`else
    repeat (20) step();
    vecs++;
    if (bus.report_timeout !== 1'b0 || bus.report_valid !== 1'b1) begin
      errs++;
      $display("FAIL to_disabled: got to=%b valid=%b want 0 1", bus.report_timeout, bus.report_valid);
    end
    bus.report_errors_ack = 1'b1;
    step();
    bus.report_errors_ack = 1'b0;
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mid_report();
    test_enable();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
